// File: rtl/mac_pkg.sv
// Shared definitions for the MAC receive path.
// Holds the FSM state encoding, the CRC-32 constants and the bit positions
// of the receive status error vector. It also provides a byte-wide CRC-32
// step function that the receive and transmit FCS paths can both use.
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_ADDR,
        S_BODY,
        S_FLUSH,
        S_DISCARD,
        S_ABORT,
        S_STATUS
    } rx_state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam int STAT_ERR_W = 3;
    localparam int ERR_CRC    = 0;
    localparam int ERR_LEN    = 1;
    localparam int ERR_OVF    = 2;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/mac_rx_if.sv
// Receive MAC bus bundle: byte stream in, rx_fifo write port out, status out.
//  mac_rxd / mac_rxdv   receive byte and its valid flag
//  rx_fifo_wr_en/_data  write port into rx_fifo; rx_fifo_full back-pressure
//  rx_stat_valid/_err/_len  per-frame status word
// slave modport is the MAC side; master modport is the side feeding it.
interface mac_rx_if #(parameter int CNT_W = 11);
    import mac_pkg::*;

    logic [7:0]            mac_rxd;
    logic                  mac_rxdv;
    logic                  rx_fifo_wr_en;
    logic [7:0]            rx_fifo_wr_data;
    logic                  rx_fifo_full;
    logic                  rx_stat_valid;
    logic [STAT_ERR_W-1:0] rx_stat_err;
    logic [CNT_W-1:0]      rx_stat_len;

    modport slave (
        input  mac_rxd, mac_rxdv, rx_fifo_full,
        output rx_fifo_wr_en, rx_fifo_wr_data, rx_stat_valid, rx_stat_err, rx_stat_len
    );

    modport master (
        output mac_rxd, mac_rxdv, rx_fifo_full,
        input  rx_fifo_wr_en, rx_fifo_wr_data, rx_stat_valid, rx_stat_err, rx_stat_len
    );
endinterface

// File: rtl/mac_crc32.sv
// Byte-wide IEEE 802.3 reflected CRC-32 register.
//  clk, rst  clock, asynchronous active-high reset (register -> all ones)
//  init      reload all ones (takes priority over en)
//  en        fold data into the register
//  data      input byte
//  crc       current register value, no final inversion
module mac_crc32
    import mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= CRC_INIT;
        else if (init)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc32_byte(crc, data);
    end

endmodule

// File: rtl/mac_rx.sv
// Receive-side MAC framer.
// Strips preamble/SFD, checks CRC-32 and frame length, and writes dest..payload
// into rx_fifo through a 6-byte delay line so the 4 FCS bytes never reach the
// fifo. One status word is produced per accepted frame.
//  clk, rst  clock, asynchronous active-high reset
//  bus       mac_rx_if.slave: mac_rxd/mac_rxdv in, rx_fifo write port out,
//            rx_fifo_full in, rx_stat_valid/err/len out
// Optional feature: RX_ADDR_FILTER_EN enables destination address filtering
// (MY_MAC or broadcast accepted, others dropped silently).
module mac_rx
    import mac_pkg::*;
#(
    parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
    parameter logic [7:0]  SFD_BYTE      = 8'hD5,
    parameter logic [47:0] MY_MAC        = 48'h02_00_00_00_00_01,
    parameter int          MIN_FRAME     = 64,
    parameter int          MAX_FRAME     = 1518,
    parameter int          COUNTER_WIDTH = 11
) (
    input logic      clk,
    input logic      rst,
    mac_rx_if.slave  bus
);

`ifdef RX_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam logic [COUNTER_WIDTH-1:0] MIN_C = COUNTER_WIDTH'(MIN_FRAME);
    localparam logic [COUNTER_WIDTH-1:0] MAX_C = COUNTER_WIDTH'(MAX_FRAME);
    localparam logic [COUNTER_WIDTH-1:0] ONE   = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] FCS_N = COUNTER_WIDTH'(4);

    rx_state_t                state;
    logic [47:0]              dly;
    logic [COUNTER_WIDTH-1:0] byte_count;
    logic [COUNTER_WIDTH-1:0] wr_count;
    logic [2:0]               addr_cnt;
    logic                     flush_cnt;
    logic [STAT_ERR_W-1:0]    err_lat;

    logic                     crc_init, crc_en;
    logic [31:0]              crc;
    logic [COUNTER_WIDTH-1:0] next_count;
    logic [47:0]              dest_addr;
    logic                     addr_ok;

    always_comb begin
        crc_init   = (state == S_PREAMBLE) && bus.mac_rxdv && (bus.mac_rxd == SFD_BYTE);
        crc_en     = bus.mac_rxdv && ((state == S_ADDR) || (state == S_BODY));
        next_count = (byte_count == '1) ? byte_count : byte_count + ONE;
        // Full destination address as it will sit in the delay line after the 6th byte.
        dest_addr  = {dly[39:0], bus.mac_rxd};
        addr_ok    = !FILTER_EN || (dest_addr == MY_MAC) || (dest_addr == 48'hFFFF_FFFF_FFFF);
    end

    mac_crc32 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (bus.mac_rxd),
        .crc  (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            dly                 <= '0;
            byte_count          <= '0;
            wr_count            <= '0;
            addr_cnt            <= '0;
            flush_cnt           <= 1'b0;
            err_lat             <= '0;
            bus.rx_fifo_wr_en   <= 1'b0;
            bus.rx_fifo_wr_data <= '0;
            bus.rx_stat_valid   <= 1'b0;
            bus.rx_stat_err     <= '0;
            bus.rx_stat_len     <= '0;
        end else begin
            bus.rx_fifo_wr_en <= 1'b0;
            bus.rx_stat_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.mac_rxdv)
                        state <= (bus.mac_rxd == PREAMBLE_BYTE) ? S_PREAMBLE : S_DISCARD;
                end
                S_PREAMBLE: begin
                    if (!bus.mac_rxdv)
                        state <= S_IDLE;
                    else if (bus.mac_rxd == SFD_BYTE) begin
                        state      <= S_ADDR;
                        byte_count <= '0;
                        wr_count   <= '0;
                        addr_cnt   <= '0;
                        err_lat    <= '0;
                        dly        <= '0;
                    end else if (bus.mac_rxd != PREAMBLE_BYTE)
                        state <= S_DISCARD;
                end
                S_ADDR: begin
                    if (!bus.mac_rxdv) begin
                        err_lat[ERR_LEN] <= 1'b1;
                        state            <= S_ABORT;
                    end else begin
                        dly        <= dest_addr;
                        byte_count <= next_count;
                        addr_cnt   <= addr_cnt + 3'd1;
                        if (addr_cnt == 3'd5)
                            state <= addr_ok ? S_BODY : S_DISCARD;
                    end
                end
                S_BODY: begin
                    if (!bus.mac_rxdv) begin
                        flush_cnt <= 1'b0;
                        state     <= S_FLUSH;
                    end else if (next_count > MAX_C) begin
                        err_lat[ERR_LEN] <= 1'b1;
                        state            <= S_ABORT;
                    end else if (bus.rx_fifo_full) begin
                        err_lat[ERR_OVF] <= 1'b1;
                        state            <= S_ABORT;
                    end else begin
                        // Oldest byte leaves the delay line; the newest 4 are
                        // always the FCS candidates and stay behind.
                        dly                 <= dest_addr;
                        byte_count          <= next_count;
                        bus.rx_fifo_wr_en   <= 1'b1;
                        bus.rx_fifo_wr_data <= dly[47:40];
                        wr_count            <= wr_count + ONE;
                    end
                end
                S_FLUSH: begin
                    if (bus.rx_fifo_full) begin
                        err_lat[ERR_OVF] <= 1'b1;
                        state            <= S_ABORT;
                    end else begin
                        bus.rx_fifo_wr_en   <= 1'b1;
                        bus.rx_fifo_wr_data <= dly[47:40];
                        dly                 <= {dly[39:0], 8'h00};
                        wr_count            <= wr_count + ONE;
                        flush_cnt           <= 1'b1;
                        if (flush_cnt) begin
                            // Status registers load on entry so the pulse lines up with STATUS.
                            state             <= S_STATUS;
                            bus.rx_stat_valid <= 1'b1;
                            bus.rx_stat_err   <= {1'b0, byte_count < MIN_C, crc != CRC_RESIDUE};
                            bus.rx_stat_len   <= byte_count - FCS_N;
                        end
                    end
                end
                S_ABORT: begin
                    if (!bus.mac_rxdv) begin
                        state             <= S_STATUS;
                        bus.rx_stat_valid <= 1'b1;
                        bus.rx_stat_err   <= err_lat;
                        bus.rx_stat_len   <= wr_count;
                    end
                end
                S_STATUS: state <= S_IDLE;
                S_DISCARD: begin
                    if (!bus.mac_rxdv)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_rx.sv
module tb_mac_rx;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_rx_if bus ();

    mac_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0]  frame_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_wr[$];
    logic [2:0]  obs_err[$];
    logic [10:0] obs_len[$];

    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MY     = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER  = 48'h02_00_00_00_00_02;

    // Monitor: collects every fifo write and status word the DUT produces.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_fifo_wr_en) obs_wr.push_back(bus.rx_fifo_wr_data);
            if (bus.rx_stat_valid) begin
                obs_err.push_back(bus.rx_stat_err);
                obs_len.push_back(bus.rx_stat_len);
            end
        end
    end

    // Bit-serial reference CRC over the first n frame bytes, returned inverted (FCS value).
    function automatic logic [31:0] fcs_of(int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            b = frame_q[i];
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB8_8320;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dest, input int total);
        logic [31:0] f;
        logic [47:0] src;
        src = 48'h0A_0B_0C_0D_0E_0F;
        frame_q.delete();
        for (int i = 5; i >= 0; i--) frame_q.push_back(dest[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(src[i*8 +: 8]);
        frame_q.push_back(8'h08);
        frame_q.push_back(8'h00);
        for (int i = 0; i < total - 18; i++) frame_q.push_back(8'((i * 7 + 3) ^ $urandom_range(0, 255)));
        f = fcs_of(total - 4);
        for (int i = 0; i < 4; i++) frame_q.push_back(f[i*8 +: 8]);
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_err.delete();
        obs_len.delete();
        exp_q.delete();
    endtask

    // Drives preamble, sfd and frame_q; expected writes are queued as the
    // payload is driven (all but the last 4 bytes, and only below n_exp).
    task automatic send_frame(input logic [7:0] sfd, input int full_at, input int n_exp);
        bus.mac_rxdv = 1'b1;
        for (int p = 0; p < 7; p++) begin
            bus.mac_rxd = 8'h55;
            @(negedge clk);
        end
        bus.mac_rxd = sfd;
        @(negedge clk);
        for (int i = 0; i < frame_q.size(); i++) begin
            bus.mac_rxd      = frame_q[i];
            bus.rx_fifo_full = (i == full_at);
            if (i < n_exp) exp_q.push_back(frame_q[i]);
            @(negedge clk);
        end
        bus.mac_rxdv     = 1'b0;
        bus.rx_fifo_full = 1'b0;
        bus.mac_rxd      = 8'h00;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.rx_fifo_wr_en !== 1'b0 || bus.rx_fifo_wr_data !== 8'h00 || bus.rx_stat_valid !== 1'b0 ||
            bus.rx_stat_err !== 3'b000 || bus.rx_stat_len !== 11'd0)
            $display("FAIL reset_outputs: got wr_en=%b data=%h sv=%b err=%b len=%0d, want all 0",
                     bus.rx_fifo_wr_en, bus.rx_fifo_wr_data, bus.rx_stat_valid, bus.rx_stat_err, bus.rx_stat_len);
        else passed++;
    endtask

    task automatic test_good_frame();
        int bad;
        clear_obs();
        build_frame(BCAST, 64);
        send_frame(8'hD5, -1, 60);
        checks++;
        if (obs_wr.size() !== 60) $display("FAIL good_count: got %0d writes, want 60", obs_wr.size());
        else passed++;
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_wr.size(); i++)
            if (bad < 0 && obs_wr[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL good_data: byte %0d got %h want %h", bad, obs_wr[bad], exp_q[bad]);
        else passed++;
        checks++;
        if (obs_err.size() !== 1 || obs_err[0] !== 3'b000 || obs_len[0] !== 11'd60)
            $display("FAIL good_status: got n=%0d err=%b len=%0d, want n=1 err=000 len=60",
                     obs_err.size(), obs_err.size() ? obs_err[0] : 3'bx, obs_len.size() ? obs_len[0] : 11'bx);
        else passed++;
    endtask

    task automatic test_crc_error();
        int bad;
        clear_obs();
        build_frame(BCAST, 64);
        frame_q[34][0] = ~frame_q[34][0];
        send_frame(8'hD5, -1, 60);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_wr.size(); i++)
            if (bad < 0 && obs_wr[i] !== exp_q[i]) bad = i;
        checks++;
        if (obs_wr.size() !== 60 || bad >= 0)
            $display("FAIL crc_data: got %0d writes (first bad %0d), want 60 matching", obs_wr.size(), bad);
        else passed++;
        checks++;
        if (obs_err.size() !== 1 || obs_err[0] !== 3'b001 || obs_len[0] !== 11'd60)
            $display("FAIL crc_status: got n=%0d err=%b len=%0d, want n=1 err=001 len=60",
                     obs_err.size(), obs_err.size() ? obs_err[0] : 3'bx, obs_len.size() ? obs_len[0] : 11'bx);
        else passed++;
    endtask

    task automatic test_short_frame();
        int bad;
        clear_obs();
        build_frame(BCAST, 40);
        send_frame(8'hD5, -1, 36);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_wr.size(); i++)
            if (bad < 0 && obs_wr[i] !== exp_q[i]) bad = i;
        checks++;
        if (obs_wr.size() !== 36 || bad >= 0)
            $display("FAIL short_data: got %0d writes (first bad %0d), want 36 matching", obs_wr.size(), bad);
        else passed++;
        checks++;
        if (obs_err.size() !== 1 || obs_err[0] !== 3'b010 || obs_len[0] !== 11'd36)
            $display("FAIL short_status: got n=%0d err=%b len=%0d, want n=1 err=010 len=36",
                     obs_err.size(), obs_err.size() ? obs_err[0] : 3'bx, obs_len.size() ? obs_len[0] : 11'bx);
        else passed++;
    endtask

    task automatic test_overflow();
        int bad;
        clear_obs();
        build_frame(BCAST, 64);
        // Write of byte 20 is due while byte 26 is being received.
        send_frame(8'hD5, 26, 20);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_wr.size(); i++)
            if (bad < 0 && obs_wr[i] !== exp_q[i]) bad = i;
        checks++;
        if (obs_wr.size() !== 20 || bad >= 0)
            $display("FAIL ovf_data: got %0d writes (first bad %0d), want 20 matching", obs_wr.size(), bad);
        else passed++;
        checks++;
        if (obs_err.size() !== 1 || obs_err[0] !== 3'b100 || obs_len[0] !== 11'd20)
            $display("FAIL ovf_status: got n=%0d err=%b len=%0d, want n=1 err=100 len=20",
                     obs_err.size(), obs_err.size() ? obs_err[0] : 3'bx, obs_len.size() ? obs_len[0] : 11'bx);
        else passed++;
    endtask

    task automatic test_addr_filter();
        int bad;
        clear_obs();
        build_frame(OTHER, 64);
`ifdef RX_ADDR_FILTER_EN
        send_frame(8'hD5, -1, 0);
        checks++;
        if (obs_wr.size() !== 0 || obs_err.size() !== 0)
            $display("FAIL filter_drop: got %0d writes %0d status, want 0 and 0", obs_wr.size(), obs_err.size());
        else passed++;
        clear_obs();
        build_frame(MY, 64);
`endif
        send_frame(8'hD5, -1, 60);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_wr.size(); i++)
            if (bad < 0 && obs_wr[i] !== exp_q[i]) bad = i;
        checks++;
        if (obs_wr.size() !== 60 || bad >= 0)
            $display("FAIL filter_data: got %0d writes (first bad %0d), want 60 matching", obs_wr.size(), bad);
        else passed++;
        checks++;
        if (obs_err.size() !== 1 || obs_err[0] !== 3'b000 || obs_len[0] !== 11'd60)
            $display("FAIL filter_status: got n=%0d err=%b len=%0d, want n=1 err=000 len=60",
                     obs_err.size(), obs_err.size() ? obs_err[0] : 3'bx, obs_len.size() ? obs_len[0] : 11'bx);
        else passed++;
    endtask

    task automatic test_bad_sfd();
        clear_obs();
        build_frame(BCAST, 64);
        send_frame(8'h12, -1, 0);
        checks++;
        if (obs_wr.size() !== 0 || obs_err.size() !== 0)
            $display("FAIL bad_sfd: got %0d writes %0d status, want 0 and 0", obs_wr.size(), obs_err.size());
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        build_frame(BCAST, 64);
        bus.mac_rxdv = 1'b1;
        for (int p = 0; p < 7; p++) begin
            bus.mac_rxd = 8'h55;
            @(negedge clk);
        end
        bus.mac_rxd = 8'hD5;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            bus.mac_rxd = frame_q[i];
            @(negedge clk);
        end
        rst = 1'b1;
        bus.mac_rxdv = 1'b0;
        bus.mac_rxd  = 8'h00;
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        clear_obs();
        repeat (20) @(negedge clk);
        checks++;
        if (obs_wr.size() !== 0 || obs_err.size() !== 0)
            $display("FAIL reset_mid_silent: got %0d writes %0d status, want 0 and 0", obs_wr.size(), obs_err.size());
        else passed++;
        // Following frame must be received cleanly.
        clear_obs();
        build_frame(BCAST, 64);
        send_frame(8'hD5, -1, 60);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_wr.size(); i++)
            if (bad < 0 && obs_wr[i] !== exp_q[i]) bad = i;
        checks++;
        if (obs_wr.size() !== 60 || bad >= 0)
            $display("FAIL after_reset_data: got %0d writes (first bad %0d), want 60 matching", obs_wr.size(), bad);
        else passed++;
        checks++;
        if (obs_err.size() !== 1 || obs_err[0] !== 3'b000 || obs_len[0] !== 11'd60)
            $display("FAIL after_reset_status: got n=%0d err=%b len=%0d, want n=1 err=000 len=60",
                     obs_err.size(), obs_err.size() ? obs_err[0] : 3'bx, obs_len.size() ? obs_len[0] : 11'bx);
        else passed++;
    endtask

    initial begin
        bus.mac_rxd      = 8'h00;
        bus.mac_rxdv     = 1'b0;
        bus.rx_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_good_frame();
        test_crc_error();
        test_short_frame();
        test_overflow();
        test_addr_filter();
        test_bad_sfd();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
